// File: rtl/fifo18_pkg.sv
// fifo18_pkg: state encoding and word-format constants for the fifo18 receive scheduler
package fifo18_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_HDR    = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_DROP   = 3'd5;
    localparam logic [1:0] FLAG_TS   = 2'b11;
    localparam logic [1:0] FLAG_DATA = 2'b10;
    localparam logic [1:0] FLAG_HDR  = 2'b01;
    localparam int LEN_VALID = 17;
    localparam logic [15:0] MAX_LEN_DEFAULT = 16'd1530;
endpackage

// File: rtl/fifo18_port_mux.sv
// fifo18_port_mux: selects head word/empty of the active port and steers pops to it only
module fifo18_port_mux (
    input  logic        i_sel,
    input  logic        i_data_rd,
    input  logic        i_len_sel,
    input  logic        i_len_rd,
    input  logic [17:0] i_p0_data_dout,
    input  logic [17:0] i_p1_data_dout,
    input  logic        i_p0_data_empty,
    input  logic        i_p1_data_empty,
    input  logic [17:0] i_p0_len_dout,
    input  logic [17:0] i_p1_len_dout,
    output logic [17:0] o_data_dout,
    output logic        o_data_empty,
    output logic [17:0] o_len_dout,
    output logic        o_p0_data_rd_en,
    output logic        o_p1_data_rd_en,
    output logic        o_p0_len_rd_en,
    output logic        o_p1_len_rd_en
);
    assign o_data_dout     = i_sel ? i_p1_data_dout : i_p0_data_dout;
    assign o_data_empty    = i_sel ? i_p1_data_empty : i_p0_data_empty;
    assign o_len_dout      = i_len_sel ? i_p1_len_dout : i_p0_len_dout;
    assign o_p0_data_rd_en = i_data_rd & ~i_sel;
    assign o_p1_data_rd_en = i_data_rd & i_sel;
    assign o_p0_len_rd_en  = i_len_rd & ~i_len_sel;
    assign o_p1_len_rd_en  = i_len_rd & i_len_sel;
endmodule

// File: rtl/fifo18_rx_sched.sv
// fifo18_rx_sched: round-robin frame scheduler draining two data/length FIFO pairs into one header+data stream
module fifo18_rx_sched
    import fifo18_pkg::*;
#(
    parameter logic [15:0] MaxLen  = MAX_LEN_DEFAULT,
    parameter int          PortIdW = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [17:0]        p0_data_dout,
    input  logic               p0_data_empty,
    output logic               p0_data_rd_en,
    input  logic [17:0]        p0_len_dout,
    input  logic               p0_len_empty,
    output logic               p0_len_rd_en,
    input  logic [17:0]        p1_data_dout,
    input  logic               p1_data_empty,
    output logic               p1_data_rd_en,
    input  logic [17:0]        p1_len_dout,
    input  logic               p1_len_empty,
    output logic               p1_len_rd_en,
    output logic [17:0]        out_data,
    output logic [PortIdW-1:0] out_port,
    output logic               out_sof,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        frame_cnt0,
    output logic [31:0]        frame_cnt1,
    output logic [31:0]        drop_cnt
);
    logic [2:0]  r_state;
    logic        r_rr;
    logic        r_sel;
    logic [17:0] r_len;
    logic [15:0] r_cnt;
    logic        w_c0;
    logic        w_c1;
    logic        w_pick;
    logic        w_len_rd;
    logic        w_data_rd;
    logic        w_data_empty;
    logic [17:0] w_data_dout;
    logic [17:0] w_len_dout;
    logic [15:0] w_len;
    logic        w_unused;

    assign w_c0     = ~p0_len_empty;
    assign w_c1     = ~p1_len_empty;
    // on contention the port that was not served last wins
    assign w_pick   = (w_c0 & w_c1) ? ~r_rr : w_c1;
    assign w_len_rd = (r_state == S_IDLE) & (w_c0 | w_c1) & ~sys_rst;
    assign w_len    = r_len[15:0];
    assign w_unused = r_len[16];
    assign w_data_rd = ~w_data_empty & ((r_state == S_GAP) | (r_state == S_DROP && r_cnt != 16'd0)
                                      | (r_state == S_DATA && out_ready));
    assign out_sof   = r_state == S_HDR;
    assign out_valid = out_sof | (r_state == S_DATA && ~w_data_empty);
    assign out_data  = (r_state == S_DATA) ? w_data_dout : out_sof ? {FLAG_HDR, w_len} : 18'h0;
    assign out_port  = PortIdW'(r_sel);

    fifo18_port_mux u_mux (
        .i_sel           (r_sel),
        .i_data_rd       (w_data_rd),
        .i_len_sel       (w_pick),
        .i_len_rd        (w_len_rd),
        .i_p0_data_dout  (p0_data_dout),
        .i_p1_data_dout  (p1_data_dout),
        .i_p0_data_empty (p0_data_empty),
        .i_p1_data_empty (p1_data_empty),
        .i_p0_len_dout   (p0_len_dout),
        .i_p1_len_dout   (p1_len_dout),
        .o_data_dout     (w_data_dout),
        .o_data_empty    (w_data_empty),
        .o_len_dout      (w_len_dout),
        .o_p0_data_rd_en (p0_data_rd_en),
        .o_p1_data_rd_en (p1_data_rd_en),
        .o_p0_len_rd_en  (p0_len_rd_en),
        .o_p1_len_rd_en  (p1_len_rd_en)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_rr       <= 1'b0;
            r_sel      <= 1'b0;
            r_len      <= 18'h0;
            r_cnt      <= 16'h0;
            frame_cnt0 <= 32'h0;
            frame_cnt1 <= 32'h0;
            drop_cnt   <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: if (w_len_rd) begin
                    r_sel   <= w_pick;
                    r_len   <= w_len_dout;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_cnt   <= w_len >> 1;
                    r_state <= !r_len[LEN_VALID] ? S_GAP
                             : (w_len > MaxLen || w_len < 16'd8) ? S_DROP : S_HDR;
                end
                S_GAP: if (w_data_rd) begin
                    r_rr    <= r_sel;
                    r_state <= S_IDLE;
                end
                S_HDR: if (out_ready) r_state <= S_DATA;
                S_DATA: if (w_data_rd) begin
                    r_cnt <= r_cnt - 16'd1;
                    if (r_cnt == 16'd1) begin
                        r_rr       <= r_sel;
                        r_state    <= S_IDLE;
                        frame_cnt0 <= frame_cnt0 + {31'd0, ~r_sel};
                        frame_cnt1 <= frame_cnt1 + {31'd0, r_sel};
                    end
                end
                S_DROP: if (r_cnt == 16'd0) begin
                    drop_cnt <= drop_cnt + 32'd1;
                    r_rr     <= r_sel;
                    r_state  <= S_IDLE;
                end else if (w_data_rd) begin
                    r_cnt <= r_cnt - 16'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo18_rx_sched.sv
// tb_fifo18_rx_sched: directed scenarios against FWFT FIFO models with hand-computed expectations
module tb_fifo18_rx_sched;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [17:0] p0_data_dout = 18'h0, p1_data_dout = 18'h0, p0_len_dout = 18'h0, p1_len_dout = 18'h0;
    logic        p0_data_empty = 1'b1, p1_data_empty = 1'b1, p0_len_empty = 1'b1, p1_len_empty = 1'b1;
    logic        p0_data_rd_en, p1_data_rd_en, p0_len_rd_en, p1_len_rd_en;
    logic [17:0] out_data;
    logic        out_port, out_sof, out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] frame_cnt0, frame_cnt1, drop_cnt;
    int          n_vec = 0, n_err = 0, pops_d0 = 0, pops_d1 = 0;
    logic [17:0] q_d0[$], q_d1[$], q_l0[$], q_l1[$];
    logic [19:0] cap[$];
    logic        pop_d0 = 1'b0, pop_d1 = 1'b0, pop_l0 = 1'b0, pop_l1 = 1'b0;

    fifo18_rx_sched dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .p0_data_dout(p0_data_dout), .p0_data_empty(p0_data_empty), .p0_data_rd_en(p0_data_rd_en),
        .p0_len_dout(p0_len_dout), .p0_len_empty(p0_len_empty), .p0_len_rd_en(p0_len_rd_en),
        .p1_data_dout(p1_data_dout), .p1_data_empty(p1_data_empty), .p1_data_rd_en(p1_data_rd_en),
        .p1_len_dout(p1_len_dout), .p1_len_empty(p1_len_empty), .p1_len_rd_en(p1_len_rd_en),
        .out_data(out_data), .out_port(out_port), .out_sof(out_sof), .out_valid(out_valid),
        .out_ready(out_ready), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1), .drop_cnt(drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        {pop_d0, pop_d1, pop_l0, pop_l1} = {p0_data_rd_en, p1_data_rd_en, p0_len_rd_en, p1_len_rd_en};
        if (out_valid && out_ready && !sys_rst) cap.push_back({out_sof, out_port, out_data});
    end

    always @(posedge sys_clk) begin
        if (!sys_rst) begin
            if (pop_d0) begin
                n_vec++;
                if (p0_data_empty) begin n_err++; $display("FAIL pop_empty p0_data: rd_en=1 while empty"); end
                if (q_d0.size() != 0) begin void'(q_d0.pop_front()); pops_d0++; end
            end
            if (pop_d1) begin
                n_vec++;
                if (p1_data_empty) begin n_err++; $display("FAIL pop_empty p1_data: rd_en=1 while empty"); end
                if (q_d1.size() != 0) begin void'(q_d1.pop_front()); pops_d1++; end
            end
            if (pop_l0) begin
                n_vec++;
                if (p0_len_empty) begin n_err++; $display("FAIL pop_empty p0_len: rd_en=1 while empty"); end
                if (q_l0.size() != 0) void'(q_l0.pop_front());
            end
            if (pop_l1) begin
                n_vec++;
                if (p1_len_empty) begin n_err++; $display("FAIL pop_empty p1_len: rd_en=1 while empty"); end
                if (q_l1.size() != 0) void'(q_l1.pop_front());
            end
        end
        p0_data_empty <= q_d0.size() == 0;
        p1_data_empty <= q_d1.size() == 0;
        p0_len_empty  <= q_l0.size() == 0;
        p1_len_empty  <= q_l1.size() == 0;
        p0_data_dout  <= q_d0.size() != 0 ? q_d0[0] : 18'h0;
        p1_data_dout  <= q_d1.size() != 0 ? q_d1[0] : 18'h0;
        p0_len_dout   <= q_l0.size() != 0 ? q_l0[0] : 18'h0;
        p1_len_dout   <= q_l1.size() != 0 ? q_l1[0] : 18'h0;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge sys_clk); #1; end
    endtask

    task automatic clear_fifos();
        q_d0.delete(); q_d1.delete(); q_l0.delete(); q_l1.delete(); cap.delete();
        pops_d0 = 0; pops_d1 = 0;
    endtask

    task automatic apply_reset();
        sys_rst = 1'b1; out_ready = 1'b1;
        clear_fifos();
        tick(2);
        sys_rst = 1'b0;
        tick(1);
    endtask

    task automatic push_frame(input bit port, input logic [15:0] len, input logic [15:0] base);
        int nw;
        nw = int'(len >> 1);
        if (port) q_l1.push_back({2'b10, len}); else q_l0.push_back({2'b10, len});
        for (int i = 0; i < nw; i++) begin
            if (port) q_d1.push_back({2'b10, 16'(base + i)}); else q_d0.push_back({2'b10, 16'(base + i)});
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        int c;
        c = 0;
        while (cap.size() < n && c < budget) begin tick(); c++; end
        tick(3);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; out_ready = 1'b1;
        tick(2);
        q_l0.push_back({2'b10, 16'd64});
        tick(2);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        n_vec++; if (out_data !== 18'h0) begin n_err++; $display("FAIL rst_data got %h exp 0", out_data); end
        n_vec++; if (out_sof !== 1'b0 || out_port !== 1'b0) begin n_err++; $display("FAIL rst_sof_port got %b%b exp 00", out_sof, out_port); end
        n_vec++; if ({frame_cnt0, frame_cnt1, drop_cnt} !== 96'h0) begin n_err++; $display("FAIL rst_cnt got %h %h %h exp 0", frame_cnt0, frame_cnt1, drop_cnt); end
        n_vec++; if ({p0_data_rd_en, p1_data_rd_en, p0_len_rd_en, p1_len_rd_en} !== 4'b0) begin n_err++; $display("FAIL rst_rd_en got %b exp 0000", {p0_data_rd_en, p1_data_rd_en, p0_len_rd_en, p1_len_rd_en}); end
        clear_fifos();
    endtask

    task automatic test_single_frame();
        logic [19:0] exp;
        apply_reset();
        push_frame(0, 16'd76, 16'h0100);
        wait_words(39, 300);
        n_vec++; if (cap.size() != 39) begin n_err++; $display("FAIL single_count got %0d exp 39", cap.size()); end
        n_vec++; if (cap[0] !== {1'b1, 1'b0, 18'h1004C}) begin n_err++; $display("FAIL single_hdr got %h exp %h", cap[0], {1'b1, 1'b0, 18'h1004C}); end
        for (int i = 1; i < 39 && i < cap.size(); i++) begin
            exp = {2'b00, 2'b10, 16'(16'h0100 + i - 1)};
            n_vec++; if (cap[i] !== exp) begin n_err++; $display("FAIL single_word%0d got %h exp %h", i, cap[i], exp); end
        end
        n_vec++; if (frame_cnt0 !== 32'd1 || frame_cnt1 !== 32'd0) begin n_err++; $display("FAIL single_fcnt got %0d/%0d exp 1/0", frame_cnt0, frame_cnt1); end
        n_vec++; if (pops_d1 != 0 || pops_d0 != 38) begin n_err++; $display("FAIL single_pops got p0=%0d p1=%0d exp 38/0", pops_d0, pops_d1); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        push_frame(0, 16'd64, 16'h0200);
        push_frame(1, 16'd64, 16'h0300);
        wait_words(66, 300);
        n_vec++; if (cap.size() != 66) begin n_err++; $display("FAIL rr_count got %0d exp 66", cap.size()); end
        n_vec++; if (cap[0] !== {1'b1, 1'b1, 18'h10040}) begin n_err++; $display("FAIL rr_first_hdr got %h exp %h", cap[0], {1'b1, 1'b1, 18'h10040}); end
        n_vec++; if (cap[32] !== {1'b0, 1'b1, 2'b10, 16'h031F}) begin n_err++; $display("FAIL rr_p1_last got %h exp %h", cap[32], {1'b0, 1'b1, 2'b10, 16'h031F}); end
        n_vec++; if (cap[33] !== {1'b1, 1'b0, 18'h10040}) begin n_err++; $display("FAIL rr_second_hdr got %h exp %h", cap[33], {1'b1, 1'b0, 18'h10040}); end
        n_vec++; if (cap[65] !== {1'b0, 1'b0, 2'b10, 16'h021F}) begin n_err++; $display("FAIL rr_p0_last got %h exp %h", cap[65], {1'b0, 1'b0, 2'b10, 16'h021F}); end
        n_vec++; if (frame_cnt0 !== 32'd1 || frame_cnt1 !== 32'd1) begin n_err++; $display("FAIL rr_fcnt got %0d/%0d exp 1/1", frame_cnt0, frame_cnt1); end
    endtask

    task automatic test_gap();
        apply_reset();
        q_l0.push_back(18'h00000);
        q_d0.push_back(18'h00000);
        push_frame(0, 16'd72, 16'h0400);
        wait_words(37, 300);
        n_vec++; if (cap.size() != 37) begin n_err++; $display("FAIL gap_count got %0d exp 37", cap.size()); end
        n_vec++; if (cap[0] !== {1'b1, 1'b0, 18'h10048}) begin n_err++; $display("FAIL gap_hdr got %h exp %h", cap[0], {1'b1, 1'b0, 18'h10048}); end
        n_vec++; if (cap[1] !== {1'b0, 1'b0, 2'b10, 16'h0400}) begin n_err++; $display("FAIL gap_first got %h exp %h", cap[1], {1'b0, 1'b0, 2'b10, 16'h0400}); end
        n_vec++; if (pops_d0 != 37 || drop_cnt !== 32'd0 || frame_cnt0 !== 32'd1) begin n_err++; $display("FAIL gap_counts got pops=%0d drop=%0d fcnt=%0d exp 37/0/1", pops_d0, drop_cnt, frame_cnt0); end
    endtask

    task automatic test_oversize_drop();
        apply_reset();
        push_frame(1, 16'h0800, 16'h1000);
        push_frame(1, 16'd64, 16'h0500);
        wait_words(33, 2000);
        n_vec++; if (cap.size() != 33) begin n_err++; $display("FAIL drop_count got %0d exp 33", cap.size()); end
        n_vec++; if (cap[0] !== {1'b1, 1'b1, 18'h10040}) begin n_err++; $display("FAIL drop_next_hdr got %h exp %h", cap[0], {1'b1, 1'b1, 18'h10040}); end
        n_vec++; if (cap[1] !== {1'b0, 1'b1, 2'b10, 16'h0500}) begin n_err++; $display("FAIL drop_next_word got %h exp %h", cap[1], {1'b0, 1'b1, 2'b10, 16'h0500}); end
        n_vec++; if (drop_cnt !== 32'd1 || frame_cnt1 !== 32'd1) begin n_err++; $display("FAIL drop_cnts got drop=%0d fcnt1=%0d exp 1/1", drop_cnt, frame_cnt1); end
        n_vec++; if (pops_d1 != 1056 || pops_d0 != 0) begin n_err++; $display("FAIL drop_pops got p1=%0d p0=%0d exp 1056/0", pops_d1, pops_d0); end
    endtask

    task automatic test_length_bounds();
        apply_reset();
        push_frame(0, 16'd0, 16'h0000);
        push_frame(0, 16'd6, 16'h0600);
        push_frame(0, 16'd1531, 16'h0700);
        push_frame(0, 16'd1530, 16'h0800);
        push_frame(0, 16'd8, 16'h0C00);
        wait_words(771, 3000);
        n_vec++; if (cap.size() != 771) begin n_err++; $display("FAIL bounds_count got %0d exp 771", cap.size()); end
        n_vec++; if (cap[0] !== {1'b1, 1'b0, 18'h105FA}) begin n_err++; $display("FAIL bounds_max_hdr got %h exp %h", cap[0], {1'b1, 1'b0, 18'h105FA}); end
        n_vec++; if (cap[765] !== {1'b0, 1'b0, 2'b10, 16'h0AFC}) begin n_err++; $display("FAIL bounds_max_last got %h exp %h", cap[765], {1'b0, 1'b0, 2'b10, 16'h0AFC}); end
        n_vec++; if (cap[766] !== {1'b1, 1'b0, 18'h10008}) begin n_err++; $display("FAIL bounds_min_hdr got %h exp %h", cap[766], {1'b1, 1'b0, 18'h10008}); end
        n_vec++; if (cap[770] !== {1'b0, 1'b0, 2'b10, 16'h0C03}) begin n_err++; $display("FAIL bounds_min_last got %h exp %h", cap[770], {1'b0, 1'b0, 2'b10, 16'h0C03}); end
        n_vec++; if (drop_cnt !== 32'd3 || frame_cnt0 !== 32'd2) begin n_err++; $display("FAIL bounds_cnts got drop=%0d fcnt0=%0d exp 3/2", drop_cnt, frame_cnt0); end
        n_vec++; if (pops_d0 != 1537) begin n_err++; $display("FAIL bounds_pops got %0d exp 1537", pops_d0); end
    endtask

    task automatic test_back_to_back_stall();
        int cyc, refill, n_stall;
        logic prev_stall;
        logic [17:0] prev_data;
        logic [19:0] exp;
        apply_reset();
        q_l0.push_back({2'b10, 16'd64});
        for (int i = 0; i < 10; i++) q_d0.push_back({2'b10, 16'(16'h0D00 + i)});
        cyc = 0; refill = -1; n_stall = 0; prev_stall = 1'b0; prev_data = 18'h0;
        while (cap.size() < 33 && cyc < 600) begin
            @(posedge sys_clk); #1;
            out_ready = ~out_ready;
            if (refill < 0 && cap.size() >= 11) refill = cyc + 6;
            if (cyc == refill) for (int i = 10; i < 32; i++) q_d0.push_back({2'b10, 16'(16'h0D00 + i)});
            @(negedge sys_clk);
            if (prev_stall) begin
                n_stall++;
                n_vec++; if (out_valid !== 1'b1 || out_data !== prev_data) begin n_err++; $display("FAIL stall_hold got v=%b d=%h exp v=1 d=%h", out_valid, out_data, prev_data); end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            cyc++;
        end
        out_ready = 1'b1;
        tick(3);
        n_vec++; if (n_stall == 0) begin n_err++; $display("FAIL stall_seen got 0 stalled cycles exp >0"); end
        n_vec++; if (cap.size() != 33) begin n_err++; $display("FAIL stall_count got %0d exp 33", cap.size()); end
        for (int i = 1; i < 33 && i < cap.size(); i++) begin
            exp = {2'b00, 2'b10, 16'(16'h0D00 + i - 1)};
            n_vec++; if (cap[i] !== exp) begin n_err++; $display("FAIL stall_word%0d got %h exp %h", i, cap[i], exp); end
        end
        n_vec++; if (frame_cnt0 !== 32'd1) begin n_err++; $display("FAIL stall_fcnt got %0d exp 1", frame_cnt0); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        push_frame(0, 16'd64, 16'h0E00);
        wait_words(33, 300);
        n_vec++; if (frame_cnt0 !== 32'd1) begin n_err++; $display("FAIL arst_pre_fcnt got %0d exp 1", frame_cnt0); end
        push_frame(0, 16'd64, 16'h0F00);
        wait_words(38, 300);
        @(posedge sys_clk); #2;
        sys_rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_data !== 18'h0 || out_sof !== 1'b0) begin n_err++; $display("FAIL arst_out got v=%b d=%h s=%b exp 0/0/0", out_valid, out_data, out_sof); end
        n_vec++; if (frame_cnt0 !== 32'd0) begin n_err++; $display("FAIL arst_fcnt got %0d exp 0", frame_cnt0); end
        n_vec++; if (p0_data_rd_en !== 1'b0 || p0_len_rd_en !== 1'b0) begin n_err++; $display("FAIL arst_rd_en got %b%b exp 00", p0_data_rd_en, p0_len_rd_en); end
        clear_fifos();
        tick(2);
        sys_rst = 1'b0;
        tick(1);
        push_frame(0, 16'd16, 16'h1100);
        wait_words(9, 200);
        n_vec++; if (cap.size() != 9 || cap[0] !== {1'b1, 1'b0, 18'h10010}) begin n_err++; $display("FAIL arst_after got n=%0d hdr=%h exp 9 %h", cap.size(), cap[0], {1'b1, 1'b0, 18'h10010}); end
        n_vec++; if (frame_cnt0 !== 32'd1) begin n_err++; $display("FAIL arst_after_fcnt got %0d exp 1", frame_cnt0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_gap();
        test_oversize_drop();
        test_length_bounds();
        test_back_to_back_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
